// File: rtl/fx_pcs_pkg.sv
// Shared 100BASE-X PCS definitions: code groups, encoder FSM states, 4B/5B data table
// and the NRZI helper used when FX_NRZI_EN is defined.
package fx_pcs_pkg;

  localparam logic [4:0] CG_IDLE = 5'b11111;
  localparam logic [4:0] CG_J    = 5'b11000;
  localparam logic [4:0] CG_K    = 5'b10001;
  localparam logic [4:0] CG_T    = 5'b01101;
  localparam logic [4:0] CG_R    = 5'b00111;
  localparam logic [4:0] CG_H    = 5'b00100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SSD_K = 3'd1,
    ST_DATA  = 3'd2,
    ST_ESD_T = 3'd3,
    ST_ESD_R = 3'd4,
    ST_GAP   = 3'd5
  } fx_state_e;

  function automatic logic [4:0] data_cg(input logic [3:0] nib);
    logic [4:0] cg;
    case (nib)
      4'h0:    cg = 5'b11110;
      4'h1:    cg = 5'b01001;
      4'h2:    cg = 5'b10100;
      4'h3:    cg = 5'b10101;
      4'h4:    cg = 5'b01010;
      4'h5:    cg = 5'b01011;
      4'h6:    cg = 5'b01110;
      4'h7:    cg = 5'b01111;
      4'h8:    cg = 5'b10010;
      4'h9:    cg = 5'b10011;
      4'hA:    cg = 5'b10110;
      4'hB:    cg = 5'b10111;
      4'hC:    cg = 5'b11010;
      4'hD:    cg = 5'b11011;
      4'hE:    cg = 5'b11100;
      4'hF:    cg = 5'b11101;
      default: cg = CG_IDLE;
    endcase
    return cg;
  endfunction

  // Bit4 leaves first; each output bit is the line level after that bit.
  function automatic logic [4:0] nrzi_encode(input logic [4:0] sym, input logic lvl_in);
    logic [4:0] code;
    logic       lvl;
    lvl = lvl_in;
    for (int i = 4; i >= 0; i--) begin
      lvl     = lvl ^ sym[i];
      code[i] = lvl;
    end
    return code;
  endfunction

endpackage

// File: rtl/fx_4b5b_lut.sv
// Combinational 4B/5B data mapping: MII nibble to 5-bit data code group.
module fx_4b5b_lut
  import fx_pcs_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [4:0] o_cg
);

  always_comb begin
    o_cg = data_cg(i_nib);
  end

endmodule

// File: rtl/fx_4b5b_encoder.sv
// 100BASE-X PCS transmit encoder: MII nibbles to 4B/5B code groups with J/K, T/R, IDLE
// and minimum IPG enforcement. Define FX_NRZI_EN to add the registered o_nrzi output.
module fx_4b5b_encoder
  import fx_pcs_pkg::*;
#(
  parameter int MIN_IPG = 24,
  parameter int CNT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_mii_tx_en,
  input  logic       i_mii_tx_er,
  input  logic [3:0] i_mii_txd,
  output logic [4:0] o_sym,
  output logic       o_active,
  output logic       o_drop
`ifdef FX_NRZI_EN
  ,
  output logic [4:0] o_nrzi
`endif
);

  localparam logic [CNT_W-1:0] IPG_MIN = CNT_W'(MIN_IPG);

  fx_state_e        r_state;
  logic [CNT_W-1:0] r_ipg;
  logic [4:0]       r_sym;
  logic             r_active;
  logic             r_drop;
  logic [4:0]       w_data;
  logic [4:0]       w_sym_nxt;
  logic             w_ipg_ok;

  fx_4b5b_lut u_lut (
    .i_nib (i_mii_txd),
    .o_cg  (w_data)
  );

  assign w_ipg_ok = (r_ipg >= IPG_MIN);

  always_comb begin
    w_sym_nxt = CG_IDLE;
    case (r_state)
      ST_IDLE:  w_sym_nxt = (i_mii_tx_en && w_ipg_ok) ? CG_J : CG_IDLE;
      ST_SSD_K: w_sym_nxt = CG_K;
      ST_DATA:  w_sym_nxt = !i_mii_tx_en ? CG_T : (i_mii_tx_er ? CG_H : w_data);
      ST_ESD_T: w_sym_nxt = CG_T;
      ST_ESD_R: w_sym_nxt = CG_R;
      ST_GAP:   w_sym_nxt = CG_IDLE;
      default:  w_sym_nxt = CG_IDLE;
    endcase
  end

  // The IPG counter only advances while IDLE is sent from ST_IDLE; a rejected start still counts.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state  <= ST_IDLE;
      r_ipg    <= IPG_MIN;
      r_sym    <= CG_IDLE;
      r_active <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_sym <= w_sym_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_mii_tx_en && w_ipg_ok) begin
            r_state  <= ST_SSD_K;
            r_active <= 1'b1;
            r_drop   <= 1'b0;
          end else begin
            r_state  <= i_mii_tx_en ? ST_GAP : ST_IDLE;
            r_active <= 1'b0;
            r_drop   <= i_mii_tx_en;
            if (!w_ipg_ok) begin
              r_ipg <= r_ipg + CNT_W'(1);
            end else begin
              r_ipg <= r_ipg;
            end
          end
        end
        ST_SSD_K: begin
          r_state  <= i_mii_tx_en ? ST_DATA : ST_ESD_T;
          r_active <= 1'b1;
          r_drop   <= 1'b0;
        end
        ST_DATA: begin
          r_state  <= i_mii_tx_en ? ST_DATA : ST_ESD_R;
          r_active <= 1'b1;
          r_drop   <= 1'b0;
        end
        ST_ESD_T: begin
          r_state  <= ST_ESD_R;
          r_active <= 1'b1;
          r_drop   <= 1'b0;
        end
        ST_ESD_R: begin
          r_state  <= ST_IDLE;
          r_ipg    <= '0;
          r_active <= 1'b1;
          r_drop   <= 1'b0;
        end
        ST_GAP: begin
          r_state  <= i_mii_tx_en ? ST_GAP : ST_IDLE;
          r_active <= 1'b0;
          r_drop   <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_drop   <= 1'b0;
        end
      endcase
    end
  end

  assign o_sym    = r_sym;
  assign o_active = r_active;
  assign o_drop   = r_drop;

`ifdef FX_NRZI_EN
  logic       r_lvl;
  logic [4:0] r_nrzi;
  logic [4:0] w_nrzi_nxt;

  assign w_nrzi_nxt = nrzi_encode(w_sym_nxt, r_lvl);

  // Encodes the same code group being registered into r_sym, so both stay aligned.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_lvl  <= 1'b0;
      r_nrzi <= 5'b00000;
    end else begin
      r_lvl  <= w_nrzi_nxt[0];
      r_nrzi <= w_nrzi_nxt;
    end
  end

  assign o_nrzi = r_nrzi;
`endif

endmodule

// File: tb/tb_fx_4b5b_encoder.sv
// Self-checking bench for fx_4b5b_encoder: directed frames plus random traffic against
// a stream-level reference model.
module tb_fx_4b5b_encoder;

  localparam int MIN_IPG = 24;
  localparam logic [4:0] E_IDLE = 5'b11111;
  localparam logic [4:0] E_J    = 5'b11000;
  localparam logic [4:0] E_K    = 5'b10001;
  localparam logic [4:0] E_T    = 5'b01101;
  localparam logic [4:0] E_R    = 5'b00111;
  localparam logic [4:0] E_H    = 5'b00100;

  logic [4:0] tbl [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                           5'b01010, 5'b01011, 5'b01110, 5'b01111,
                           5'b10010, 5'b10011, 5'b10110, 5'b10111,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101};

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic [3:0] txd = 4'h0;
  logic [4:0] o_sym;
  logic       o_active;
  logic       o_drop;
`ifdef FX_NRZI_EN
  logic [4:0] o_nrzi;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int act_cnt = 0;
  int drop_cnt = 0;

  // reference model state
  logic [4:0] pend[$];
  bit         m_in_frame;
  bit         m_kslot;
  bit         m_discard;
  int         m_ipg;
  logic       m_lvl;

  fx_4b5b_encoder #(.MIN_IPG(MIN_IPG), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_res       (res),
    .i_mii_tx_en (tx_en),
    .i_mii_tx_er (tx_er),
    .i_mii_txd   (txd),
    .o_sym       (o_sym),
    .o_active    (o_active),
    .o_drop      (o_drop)
`ifdef FX_NRZI_EN
    ,
    .o_nrzi      (o_nrzi)
`endif
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_in_frame = 1'b0;
    m_kslot    = 1'b0;
    m_discard  = 1'b0;
    m_ipg      = MIN_IPG;
    m_lvl      = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_sym", 32'(o_sym), 32'(E_IDLE));
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_drop", 32'(o_drop), 32'd0);
`ifdef FX_NRZI_EN
    chk("rst_nrzi", 32'(o_nrzi), 32'd0);
`endif
    res = 1'b0;
  endtask

  // One MII cycle: apply inputs, predict the code group, check it one clock later.
  task automatic step(input logic en, input logic er, input logic [3:0] d);
    logic [4:0] es;
    logic [4:0] en_nrzi;
    logic       ea;
    logic       ed;
    tx_en = en;
    tx_er = er;
    txd   = d;
    ea = 1'b1;
    ed = 1'b0;
    es = E_IDLE;
    if (pend.size() > 0) begin
      es = pend.pop_front();
      if (es == E_R) m_ipg = 0;
    end else if (m_in_frame) begin
      if (m_kslot) begin
        es = E_K;
        m_kslot = 1'b0;
        if (!en) begin
          pend.push_back(E_T);
          pend.push_back(E_R);
          m_in_frame = 1'b0;
        end
      end else if (en) begin
        es = er ? E_H : tbl[d];
      end else begin
        es = E_T;
        pend.push_back(E_R);
        m_in_frame = 1'b0;
      end
    end else if (m_discard) begin
      ea = 1'b0;
      if (!en) m_discard = 1'b0;
    end else if (en && m_ipg >= MIN_IPG) begin
      es = E_J;
      m_in_frame = 1'b1;
      m_kslot = 1'b1;
    end else begin
      ea = 1'b0;
      if (m_ipg < MIN_IPG) m_ipg++;
      if (en) begin
        ed = 1'b1;
        m_discard = 1'b1;
      end
    end
    for (int i = 4; i >= 0; i--) begin
      if (es[i]) m_lvl = ~m_lvl;
      en_nrzi[i] = m_lvl;
    end
    @(posedge clk);
    #1;
    chk("sym", 32'(o_sym), 32'(es));
    chk("active", 32'(o_active), 32'(ea));
    chk("drop", 32'(o_drop), 32'(ed));
`ifdef FX_NRZI_EN
    chk("nrzi", 32'(o_nrzi), 32'(en_nrzi));
`endif
    if (o_active) act_cnt++;
    if (o_drop) drop_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic frame55d(input int len, input int er_idx);
    for (int i = 0; i < len; i++) step(1'b1, (i == er_idx), (i == len - 1) ? 4'hD : 4'h5);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
`ifdef FX_NRZI_EN
    step(1'b0, 1'b0, 4'h0);
    chk("nrzi_idle1", 32'(o_nrzi), 32'(5'b10101));
    step(1'b0, 1'b0, 4'h0);
    chk("nrzi_idle2", 32'(o_nrzi), 32'(5'b01010));
`endif
    idle(10);

    // 16-nibble frame: J,K,data,T,R -> 18 active cycles
    act_cnt = 0;
    frame55d(16, -1);
    idle(4);
    chk("frame_active_cycles", 32'(act_cnt), 32'd18);

    // same frame with an error nibble, after a full gap
    idle(30);
    frame55d(16, 6);
    idle(3);

    // request 10 cycles after R is rejected once, then a late one starts
    drop_cnt = 0;
    idle(7);
    frame55d(8, -1);
    idle(3);
    chk("drop_count", 32'(drop_cnt), 32'd1);
    idle(30);
    frame55d(5, -1);
    idle(30);

    // single-cycle tx_en pulse -> J,K,T,R
    act_cnt = 0;
    step(1'b1, 1'b0, 4'h3);
    idle(5);
    chk("pulse_active_cycles", 32'(act_cnt), 32'd4);
    idle(30);

    // tx_er outside DATA is ignored
    step(1'b0, 1'b1, 4'h7);
    step(1'b1, 1'b1, 4'h7);
    step(1'b1, 1'b1, 4'h7);
    step(1'b1, 1'b0, 4'h9);
    idle(30);

    // reset during DATA truncates the stream
    frame55d(6, -1);
    tx_en = 1'b1;
    do_reset();
    idle(3);

    // random traffic
    for (int f = 0; f < 60; f++) begin
      int gap;
      int len;
      gap = $urandom_range(0, 40);
      len = $urandom_range(1, 30);
      for (int i = 0; i < gap; i++) step(1'b0, ($urandom_range(0, 7) == 0), 4'($urandom));
      for (int i = 0; i < len; i++) step(1'b1, ($urandom_range(0, 7) == 0), 4'($urandom));
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
